// File: rtl/pc_sequencer.sv
// Fetch-side program counter sequencer: start, stall hold, redirect with flush bubbles, halt/restart.
// Optional build macro MISALIGN_TRAP_EN: misaligned redirect targets trap to HALT and raise error.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic [1:0]  state,
    output logic [31:0] instr_count,
    output logic        error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_q, flush_d;
    logic [31:0]      count_q, count_d;
    logic             error_q, error_d;

    logic             issue;
    logic             take_redir;
    logic             misaligned;
    logic [31:0]      target_pc;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (redirect_target[1:0] != 2'b00);
    assign target_pc  = redirect_target;
`else
    // Low bits are dropped so the core never sees a misaligned fetch address.
    assign misaligned = 1'b0;
    assign target_pc  = redirect_target & 32'hFFFF_FFFC;
`endif

    assign issue = (state_q == ST_RUN) && !stall && !halt_req && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        count_d    = count_q;
        error_d    = error_q;
        take_redir = 1'b0;

        if (issue && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (redirect_valid) begin
                    take_redir = 1'b1;
                end else if (!stall) begin
                    pc_d = pc_q + STEP;
                end
            end
            ST_FLUSH: begin
                // Stall is deliberately not consulted: bubbles drain regardless.
                if (halt_req) begin
                    state_d = ST_HALT;
                    flush_d = 1'b0;
                end else if (redirect_valid) begin
                    take_redir = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                    count_d = '0;
                    error_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_redir) begin
            if (misaligned) begin
                state_d = ST_HALT;
                flush_d = 1'b0;
                error_d = 1'b1;
            end else begin
                pc_d    = target_pc;
                state_d = ST_FLUSH;
                cnt_d   = CNT_RELOAD;
                flush_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign pc          = pc_q;
    assign pc_valid    = issue;
    assign flush       = flush_q;
    assign state       = state_q;
    assign instr_count = count_q;
    assign error       = error_q;

endmodule
